// File: rtl/sram_burst_io_ctrl.sv
// sram_burst_io_ctrl: serial command bridge to a single-port SRAM.
// A header selects a write or read burst; returns to IDLE after each command.
module sram_burst_io_ctrl #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int BURST_LEN_WIDTH   = 4
) (
  input  logic                         CLK,
  input  logic                         BGN,
  input  logic                         LOAD_N,
  input  logic                         SI,
  output logic                         SO,
  output logic                         SO_VLD,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q,
  output logic                         CEN,
  output logic                         WEN
);

  localparam int DW = MEMORY_DATA_WIDTH;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int LW = BURST_LEN_WIDTH;
  localparam int HW = 1 + AW + LW;
  localparam int MB = (HW > DW) ? HW : DW;
  localparam int CW = $clog2(MB);

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [LW-1:0] L_ONE = LW'(1);
  localparam logic [CW-1:0] C_HDR = CW'(HW - 1);
  localparam logic [CW-1:0] C_DAT = CW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WLD,
    S_WR,
    S_RD,
    S_RCAP,
    S_RSH,
    S_DONE
  } st_e;

  st_e           st_q;
  logic [CW-1:0] bit_q;
  logic [HW-1:0] hdr_q;
  logic [DW-1:0] dat_q;
  logic [AW-1:0] adr_q;
  logic [LW-1:0] wc_q;
  logic          cen_q;
  logic          wen_q;
  logic          so_q;
  logic          vld_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q;

  logic [HW-1:0] hdr_d;
  logic [DW-1:0] dat_d;
  logic [DW-1:0] dat_sh;
  logic [AW-1:0] adr_d;
  logic [AW-1:0] hdr_adr;
  logic [LW-1:0] hdr_len;
  logic          hdr_last;
  logic          dat_last;

  // Both shifters fill from the top so the first bit lands in bit 0.
  assign hdr_d    = {SI, hdr_q[HW-1:1]};
  assign dat_d    = {SI, dat_q[DW-1:1]};
  assign dat_sh   = dat_q >> 1;
  assign adr_d    = adr_q + A_ONE;
  assign hdr_adr  = hdr_d[AW:1];
  assign hdr_len  = hdr_d[HW-1 -: LW];
  assign hdr_last = (bit_q == C_HDR);
  assign dat_last = (bit_q == C_DAT);

  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      st_q   <= S_IDLE;
      bit_q  <= '0;
      hdr_q  <= '0;
      dat_q  <= '0;
      adr_q  <= '0;
      wc_q   <= '0;
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
      so_q   <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      d_q    <= '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          bit_q <= '0;
          if (!LOAD_N) begin
            st_q   <= S_HDR;
            busy_q <= 1'b1;
          end
        end
        S_HDR: begin
          hdr_q <= hdr_d;
          bit_q <= bit_q + C_ONE;
          if (hdr_last) begin
            bit_q <= '0;
            adr_q <= hdr_adr;
            wc_q  <= hdr_len;
            if (hdr_d[0]) begin
              st_q <= S_WLD;
            end else begin
              st_q  <= S_RD;
              cen_q <= 1'b0;
              a_q   <= hdr_adr;
            end
          end
        end
        S_WLD: begin
          dat_q <= dat_d;
          bit_q <= bit_q + C_ONE;
          if (dat_last) begin
            bit_q <= '0;
            st_q  <= S_WR;
            cen_q <= 1'b0;
            wen_q <= 1'b0;
            a_q   <= adr_q;
            d_q   <= dat_d;
          end
        end
        S_WR: begin
          cen_q <= 1'b1;
          wen_q <= 1'b1;
          a_q   <= '0;
          d_q   <= '0;
          adr_q <= adr_d;
          if (wc_q == '0) begin
            st_q   <= S_DONE;
            done_q <= 1'b1;
          end else begin
            wc_q <= wc_q - L_ONE;
            st_q <= S_WLD;
          end
        end
        S_RD: begin
          cen_q <= 1'b1;
          a_q   <= '0;
          st_q  <= S_RCAP;
        end
        S_RCAP: begin
          dat_q <= Q;
          so_q  <= Q[0];
          vld_q <= 1'b1;
          bit_q <= '0;
          st_q  <= S_RSH;
        end
        S_RSH: begin
          dat_q <= dat_sh;
          so_q  <= dat_sh[0];
          bit_q <= bit_q + C_ONE;
          if (dat_last) begin
            bit_q <= '0;
            so_q  <= 1'b0;
            vld_q <= 1'b0;
            adr_q <= adr_d;
            if (wc_q == '0) begin
              st_q   <= S_DONE;
              done_q <= 1'b1;
            end else begin
              wc_q  <= wc_q - L_ONE;
              st_q  <= S_RD;
              cen_q <= 1'b0;
              a_q   <= adr_d;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          st_q   <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign SO     = so_q;
  assign SO_VLD = vld_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign A      = a_q;
  assign D      = d_q;
  assign CEN    = cen_q;
  assign WEN    = wen_q;

endmodule

// File: doc/sram_burst_io_ctrl.md
Name: sram_burst_io_ctrl

Overview:
Serial-to-SRAM bridge, successor to the single-word serial SRAM loader. Takes a serial command header on SI: direction, start address and burst length. Then either shifts in and writes N data words to consecutive SRAM addresses, or reads N consecutive words and shifts each out on SO. Unlike the single-shot loader, it returns to IDLE after every command and accepts the next one without reset.

Parameters:
MEMORY_DATA_WIDTH, 8, SRAM word width (D/Q)
MEMORY_ADDR_WIDTH, 9, SRAM address width
BURST_LEN_WIDTH, 4, length field width; burst = 1..2^BURST_LEN_WIDTH words
HDR_WIDTH, 1+MEMORY_ADDR_WIDTH+BURST_LEN_WIDTH (derived, not overridable), header length in bits

Ports:
CLK  input  1  single clock; all state changes on posedge
BGN  input  1  asynchronous active-low reset
LOAD_N  input  1  active-low start; sampled only in IDLE
SI  input  1  serial in, LSB-first
SO  output  1  serial out, LSB-first
SO_VLD  output  1  high while SO carries read data
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse when a command completes
A  output  MEMORY_ADDR_WIDTH  SRAM address
D  output  MEMORY_DATA_WIDTH  SRAM write data
Q  input  MEMORY_DATA_WIDTH  SRAM read data, valid the cycle after a read access
CEN  output  1  SRAM chip enable, active low
WEN  output  1  SRAM write enable, active low

Behaviour:
- Reset (BGN=0, async): state=IDLE; all counters and shift registers=0.
- Output values during reset: CEN=1, WEN=1, A=0, D=0, SO=0, SO_VLD=0, BUSY=0, DONE=0. Outputs take these values immediately, not at the next edge.
- States and transitions:
  - IDLE -> HDR when LOAD_N=0 at a posedge.
  - HDR: samples SI on each of the next HDR_WIDTH edges.
  - After HDR: -> WLD if CMD=1, -> RD if CMD=0.
- Header bit layout (bit 0 is shifted first):
  - bit0 = CMD (1 = write, 0 = read).
  - bits[MEMORY_ADDR_WIDTH:1] = start address.
  - upper BURST_LEN_WIDTH bits = LEN; word count = LEN+1.
- Write path:
  - WLD samples SI on MEMORY_DATA_WIDTH edges.
  - -> WR for exactly 1 cycle: CEN=0, WEN=0, A=current address, D=assembled word.
  - Then address increments; if words remain -> WLD, else -> DONE.
- Read path:
  - RD for 1 cycle: CEN=0, WEN=1, A=current address.
  - -> RCAP for 1 cycle: Q captured into the shift register at the RCAP->RSH edge.
  - -> RSH for MEMORY_DATA_WIDTH cycles: SO=shift[0], SO_VLD=1, shift right each edge.
  - Then address increments; if words remain -> RD, else -> DONE.
- DONE: DONE=1 for 1 cycle -> IDLE.
- Output rules outside their active states:
  - CEN=1 and WEN=1 in every state other than WR/RD.
  - A=0 and D=0 whenever CEN=1.
  - SO=0 and SO_VLD=0 outside RSH.
- All outputs are decoded from registered state or data only; no combinational path from inputs to outputs.
- Address arithmetic is modulo 2^MEMORY_ADDR_WIDTH: max address +1 wraps to 0 silently, and the burst continues.
- LOAD_N is ignored while BUSY=1.
- If LOAD_N is still low in the IDLE cycle after DONE, a new command starts (level-sensitive). Back-to-back commands therefore have exactly 1 IDLE cycle between them.
- SI is don't-care outside HDR and WLD.
- Latency:
  - Write of N words: 1+HDR_WIDTH+N*(MEMORY_DATA_WIDTH+1)+1 cycles from the start edge to the DONE pulse.
  - Read of N words: 1+HDR_WIDTH+N*(MEMORY_DATA_WIDTH+2)+1 cycles, same reference points.
- Reset mid-operation: the command is abandoned and no partial SRAM access completes. CEN deasserts asynchronously and the next command requires a fresh header.
- Counters:
  - Bit counter sized for max(HDR_WIDTH, MEMORY_DATA_WIDTH).
  - Word counter is BURST_LEN_WIDTH bits and loads LEN (maximum LEN does not overflow).

Test Plan:
1. Single write (defaults): header CMD=1, addr 0x005, LEN=0, data 0xA5 -> one WR cycle with A=0x005, D=0xA5, CEN=0, WEN=0; DONE pulses 1 cycle after WR; BUSY then drops.
2. Burst write with wrap: addr 0x1FE, LEN=2, data 0x11, 0x22, 0x33 -> WR cycles at A=0x1FE, 0x1FF, 0x000 with matching D; total 1+14+3*9+1=43 cycles to DONE.
3. Burst read against an SRAM model preloaded 0x1FE=0x11, 0x1FF=0x22, 0x000=0x33: header CMD=0, addr 0x1FE, LEN=2 -> SO emits 0x11, 0x22, 0x33 LSB-first, each bit with SO_VLD=1; WEN stays 1; SO_VLD=0 during RD/RCAP gaps.
4. Maximum burst: LEN=15 write to 0x100 then read back -> 16 WR accesses at 0x100..0x10F; readback matches all 16 words; exactly one DONE per command.
5. Reset mid-burst: assert BGN=0 during the second WLD of a 4-word write -> CEN=1, BUSY=0 and state IDLE with no edge needed; only word 0 is written; a following fresh single write succeeds.
6. Handshake edges: pulse LOAD_N low during an active burst -> ignored, no restart. Hold LOAD_N low continuously -> exactly 1 IDLE cycle between DONE and the next HDR.
